conv2d_engine: RTL and testbench
================================

CONV2D_ENGINE -- requirements
Module: conv2d_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 7: input image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 7: input image height in pixels.
REQ-003 SHALL have parameter K, default 3: square kernel side, 1 <= K <= min(IMG_W, IMG_H).
REQ-004 SHALL have parameter STRIDE, default 1: window step in both x and y, >= 1.
REQ-005 SHALL have parameter PIX_W, default 8: unsigned pixel width.
REQ-006 SHALL have parameter WGT_W, default 8: signed two's-complement weight width.
REQ-007 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: synchronous, active-high reset (the port name is kept; polarity is high).
REQ-009 SHALL have port start, input, 1: request a new frame; honoured only in IDLE.
REQ-010 SHALL have port img, input, IMG_W*IMG_H*PIX_W: image, pixel (x,y) at bits [(y*IMG_W+x)*PIX_W +: PIX_W].
REQ-011 SHALL have port kernel, input, K*K*WGT_W: weights, (kx,ky) at bits [(ky*K+kx)*WGT_W +: WGT_W].
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port out_valid, output, 1: out_data/out_x/out_y hold a valid result.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts the result when out_valid && out_ready.
REQ-015 SHALL have port out_data, output, ACC_W: signed window sum.
REQ-016 SHALL have ports out_x and out_y, output, COORD_W each: output-grid coordinates of out_data.
REQ-017 SHALL have port done, output, 1: one-cycle pulse after the last result of a frame is accepted.

Function
REQ-018 SHALL define OUT_W=(IMG_W-K)/STRIDE+1, OUT_H=(IMG_H-K)/STRIDE+1 (integer division), COORD_W=max(1,clog2(max(OUT_W,OUT_H))), ACC_W=PIX_W+WGT_W+clog2(K*K)+1.
REQ-019 SHALL capture img and kernel into internal registers on the cycle start is accepted; later changes to the inputs do not affect the running frame.
REQ-020 SHALL implement FSM IDLE -> RUN (start in IDLE) -> FLUSH (last coordinate issued) -> IDLE (last result accepted; done pulses on that transition's following cycle = first IDLE cycle).
REQ-021 SHALL, in RUN, issue one window per cycle in raster order (x fastest), window origin (ox*STRIDE, oy*STRIDE), ox 0..OUT_W-1, oy 0..OUT_H-1, x wrapping to 0 with y increment.
REQ-022 SHALL compute out_data = sum over kx,ky of zero-extended pixel times sign-extended weight, exact in ACC_W bits, with no overflow or saturation.
REQ-023 SHALL register the result: out_valid for window n rises one cycle after window n is issued; the first result appears 2 cycles after start is accepted.
REQ-024 SHALL stall on backpressure: while out_valid && !out_ready, the coordinate counter, out_data, out_x and out_y hold unchanged.
REQ-025 SHALL sustain one result per cycle when out_ready is held high (OUT_W*OUT_H consecutive valid cycles).
REQ-026 SHALL ignore start while busy; no frame restart and no data recapture.
REQ-027 SHALL accept start in the same cycle that done is high (back-to-back frames).

Reset
REQ-028 SHALL, when rst_n=1 at a rising edge, force state to IDLE and busy, out_valid, done, out_data, out_x and out_y to 0, including in the middle of a frame; the pending result is discarded.
REQ-029 SHALL ignore start in the reset cycle; the captured-data registers need not be reset.

Structure
REQ-030 SHALL keep the derived widths (OUT_W, OUT_H, COORD_W, ACC_W) and the FSM state encodings in shared package conv_pkg.
REQ-031 SHALL place the combinational window multiply-add in sub-module conv_window_mac (parameters K, PIX_W, WGT_W; inputs window and kernel; output sum); conv2d_engine owns the counters, FSM, capture registers and output register.

Verification
REQ-032 SHALL cover defaults with all pixels=1 and all weights=1, out_ready=1 -> 25 results, each =9; done asserts 27 cycles after start.
REQ-033 SHALL cover pixel(x,y)=x+7y, centre weight=1, others 0 -> out(ox,oy)=(ox+1)+7(oy+1); raster order; out_x/out_y match.
REQ-034 SHALL cover pixels=255 and weights=-128 -> every out_data=-293760, with no wrap in ACC_W=21.
REQ-035 SHALL cover STRIDE=2, IMG 7x7 -> 3x3 results; toggling out_ready 1/0 every cycle leaves the held values stable while low, no loss and no duplicate.
REQ-036 SHALL cover rst_n=1 asserted for one cycle at result 10 -> out_valid=0 and busy=0 on the next cycle; a fresh start yields a full correct 25-result frame.
REQ-037 SHALL cover start pulsed mid-frame -> ignored, with the result count still 25; start on the done cycle -> second frame begins with no idle gap.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 2-D convolution engine: FSM states and the
// helpers that derive output-grid and accumulator widths from the parameters.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  function automatic int coord_w(input int out_w, input int out_h);
    int m;
    int c;
    m = (out_w > out_h) ? out_w : out_h;
    c = $clog2(m);
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int acc_w(input int pix_w, input int wgt_w, input int k);
    return pix_w + wgt_w + $clog2(k * k) + 1;
  endfunction

  localparam int DEF_OUT_W   = out_dim(7, 3, 1);
  localparam int DEF_OUT_H   = out_dim(7, 3, 1);
  localparam int DEF_COORD_W = coord_w(DEF_OUT_W, DEF_OUT_H);
  localparam int DEF_ACC_W   = acc_w(8, 8, 3);

endpackage

// File: rtl/conv_window_mac.sv
// Combinational multiply-add of one KxK window: unsigned pixels times signed
// weights, summed exactly in the accumulator width.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter  int K     = 3,
  parameter  int PIX_W = 8,
  parameter  int WGT_W = 8,
  localparam int ACC_W = acc_w(PIX_W, WGT_W, K)
) (
  input  logic [K*K*PIX_W-1:0]     window,
  input  logic [K*K*WGT_W-1:0]     kernel,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] wgt_ext;

  // Both operands are widened to ACC_W first so the product never truncates.
  always_comb begin
    acc     = '0;
    pix_ext = '0;
    wgt_ext = '0;
    for (int i = 0; i < K * K; i++) begin
      pix_ext = {{(ACC_W - PIX_W){1'b0}}, window[i*PIX_W +: PIX_W]};
      wgt_ext = {{(ACC_W - WGT_W){kernel[i*WGT_W + WGT_W - 1]}}, kernel[i*WGT_W +: WGT_W]};
      acc     = acc + pix_ext * wgt_ext;
    end
  end

  assign sum = acc;

endmodule

// File: rtl/conv2d_engine.sv
// Frame-based 2-D convolution: captures an image and kernel on start, then
// streams one window sum per cycle in raster order with valid/ready output.
module conv2d_engine
  import conv_pkg::*;
#(
  parameter  int IMG_W   = 7,
  parameter  int IMG_H   = 7,
  parameter  int K       = 3,
  parameter  int STRIDE  = 1,
  parameter  int PIX_W   = 8,
  parameter  int WGT_W   = 8,
  localparam int OUT_W   = out_dim(IMG_W, K, STRIDE),
  localparam int OUT_H   = out_dim(IMG_H, K, STRIDE),
  localparam int COORD_W = coord_w(OUT_W, OUT_H),
  localparam int ACC_W   = acc_w(PIX_W, WGT_W, K)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [IMG_W*IMG_H*PIX_W-1:0] img,
  input  logic [K*K*WGT_W-1:0]       kernel,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    out_data,
  output logic [COORD_W-1:0]         out_x,
  output logic [COORD_W-1:0]         out_y,
  output logic                       done
);

  state_e                      state_q, state_d;
  logic [IMG_W*IMG_H*PIX_W-1:0] img_q, img_d;
  logic [K*K*WGT_W-1:0]        kernel_q, kernel_d;
  logic [COORD_W-1:0]          ox_q, ox_d, oy_q, oy_d;
  logic [COORD_W-1:0]          out_x_q, out_x_d, out_y_q, out_y_d;
  logic signed [ACC_W-1:0]     out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        done_q, done_d;
  logic [K*K*PIX_W-1:0]        window;
  logic signed [ACC_W-1:0]     mac_sum;
  logic                        advance;
  logic                        last_x, last_y;

  // Select the KxK window whose origin is (ox*STRIDE, oy*STRIDE).
  always_comb begin
    window = '0;
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K; kx++) begin
        window[(ky*K + kx)*PIX_W +: PIX_W] =
          img_q[((int'(oy_q)*STRIDE + ky)*IMG_W + int'(ox_q)*STRIDE + kx)*PIX_W +: PIX_W];
      end
    end
  end

  conv_window_mac #(
    .K     (K),
    .PIX_W (PIX_W),
    .WGT_W (WGT_W)
  ) u_mac (
    .window (window),
    .kernel (kernel_q),
    .sum    (mac_sum)
  );

  assign last_x  = (ox_q == COORD_W'(OUT_W - 1));
  assign last_y  = (oy_q == COORD_W'(OUT_H - 1));
  assign advance = (state_q == ST_RUN) && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    img_d       = img_q;
    kernel_d    = kernel_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          img_d    = img;
          kernel_d = kernel;
          ox_d     = '0;
          oy_d     = '0;
        end
      end
      ST_RUN: begin
        // Nothing moves while a result is stuck waiting for the consumer.
        if (advance) begin
          out_valid_d = 1'b1;
          out_data_d  = mac_sum;
          out_x_d     = ox_q;
          out_y_d     = oy_q;
          if (last_x) begin
            ox_d = '0;
            if (last_y) state_d = ST_FLUSH;
            else        oy_d    = oy_q + COORD_W'(1);
          end else begin
            ox_d = ox_q + COORD_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          done_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      ox_q        <= '0;
      oy_q        <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Captured frame data carries no reset; it is always reloaded on start.
  always_ff @(posedge clk) begin
    img_q    <= img_d;
    kernel_q <= kernel_d;
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv2d_engine.sv
// Self-checking bench for conv2d_engine: table-driven frames on the default
// 7x7/K3 instance plus reset, restart and backpressure sequences on STRIDE=2.
module tb_conv2d_engine;

  localparam int IW = 7;
  localparam int KS = 3;
  localparam int PW = 8;
  localparam int WW = 8;
  localparam int OW1 = 5;
  localparam int OW2 = 3;
  localparam int AW = 21;

  typedef struct {
    int    pixMode;
    int    wgtMode;
    int    expKind;
    int    expAll;
    string name;
  } vec_t;

  logic clk;
  logic rstN;
  logic start;
  logic s2Start;
  logic [IW*IW*PW-1:0] img;
  logic [KS*KS*WW-1:0] kernel;
  logic busy, outValid, outReady, done;
  logic signed [AW-1:0] outData;
  logic [2:0] outX, outY;
  logic s2Busy, s2Valid, s2Ready, s2Done;
  logic signed [AW-1:0] s2Data;
  logic [1:0] s2X, s2Y;

  int pix [IW][IW];
  int wgt [KS][KS];
  int passed;
  int total;
  vec_t vecs [5];

  conv2d_engine dut (
    .clk(clk), .rst_n(rstN), .start(start), .img(img), .kernel(kernel),
    .busy(busy), .out_valid(outValid), .out_ready(outReady),
    .out_data(outData), .out_x(outX), .out_y(outY), .done(done)
  );

  conv2d_engine #(.STRIDE(2)) dutS2 (
    .clk(clk), .rst_n(rstN), .start(s2Start), .img(img), .kernel(kernel),
    .busy(s2Busy), .out_valid(s2Valid), .out_ready(s2Ready),
    .out_data(s2Data), .out_x(s2X), .out_y(s2Y), .done(s2Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int modelOut(input int ox, input int oy, input int stride);
    int s;
    s = 0;
    for (int ky = 0; ky < KS; ky++)
      for (int kx = 0; kx < KS; kx++)
        s += pix[oy*stride + ky][ox*stride + kx] * wgt[ky][kx];
    return s;
  endfunction

  task automatic applyStimulus(input int pixMode, input int wgtMode);
    for (int y = 0; y < IW; y++)
      for (int x = 0; x < IW; x++) begin
        case (pixMode)
          0:       pix[y][x] = 1;
          1:       pix[y][x] = x + 7 * y;
          2:       pix[y][x] = 255;
          default: pix[y][x] = int'($urandom_range(0, 255));
        endcase
        img[(y*IW + x)*PW +: PW] = 8'(pix[y][x]);
      end
    for (int ky = 0; ky < KS; ky++)
      for (int kx = 0; kx < KS; kx++) begin
        case (wgtMode)
          0:       wgt[ky][kx] = 1;
          1:       wgt[ky][kx] = (kx == 1 && ky == 1) ? 1 : 0;
          2:       wgt[ky][kx] = -128;
          default: wgt[ky][kx] = int'($urandom_range(0, 255)) - 128;
        endcase
        kernel[(ky*KS + kx)*WW +: WW] = 8'(wgt[ky][kx]);
      end
  endtask

  // Caller raises start at the current negedge (cycle 0); returns at a negedge.
  task automatic collectFrame(input int expKind, input int expAll, input int resetAt,
                              input bit midStart, input string name);
    int n, c, firstValid, doneCycle, expV;
    bit finished;
    n = 0; c = 0; firstValid = -1; doneCycle = -1; finished = 1'b0;
    while (!finished && c < 200) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (midStart && c == 10) begin
        start  = 1'b1;
        img    = ~img;
        kernel = ~kernel;
      end
      if (outValid) begin
        if (firstValid < 0) firstValid = c;
        if (outReady) begin
          case (expKind)
            1:       expV = expAll;
            2:       expV = (n % OW1 + 1) + 7 * (n / OW1 + 1);
            default: expV = modelOut(n % OW1, n / OW1, 1);
          endcase
          checkOutput($sformatf("%s.data%0d", name, n), int'(outData), expV);
          checkOutput($sformatf("%s.x%0d", name, n), int'(outX), n % OW1);
          checkOutput($sformatf("%s.y%0d", name, n), int'(outY), n / OW1);
          n++;
        end
      end
      if (done) begin
        doneCycle = c;
        finished  = 1'b1;
      end
      if (resetAt >= 0 && n == resetAt && !finished) begin
        rstN = 1'b1;
        @(negedge clk);
        checkOutput({name, ".rstValid"}, int'(outValid), 0);
        checkOutput({name, ".rstBusy"}, int'(busy), 0);
        rstN = 1'b0;
        finished = 1'b1;
      end
    end
    if (resetAt < 0) begin
      checkOutput({name, ".count"}, n, 25);
      checkOutput({name, ".firstValid"}, firstValid, 2);
      checkOutput({name, ".doneCycle"}, doneCycle, 27);
    end else begin
      checkOutput({name, ".reachedReset"}, n, resetAt);
    end
  endtask

  task automatic strideFrame();
    int n, c;
    bit holdPending, sawDone;
    int heldData, heldX, heldY;
    n = 0; c = 0; holdPending = 1'b0; sawDone = 1'b0;
    heldData = 0; heldX = 0; heldY = 0;
    applyStimulus(3, 3);
    s2Ready = 1'b1;
    s2Start = 1'b1;
    while (!sawDone && c < 200) begin
      @(negedge clk);
      c++;
      s2Start = 1'b0;
      if (holdPending) begin
        checkOutput($sformatf("s2.holdValid%0d", c), int'(s2Valid), 1);
        checkOutput($sformatf("s2.holdData%0d", c), int'(s2Data), heldData);
        checkOutput($sformatf("s2.holdXY%0d", c), int'(s2X) * 4 + int'(s2Y), heldX * 4 + heldY);
      end
      s2Ready = c[0];
      if (s2Valid && s2Ready) begin
        checkOutput($sformatf("s2.data%0d", n), int'(s2Data), modelOut(n % OW2, n / OW2, 2));
        checkOutput($sformatf("s2.x%0d", n), int'(s2X), n % OW2);
        checkOutput($sformatf("s2.y%0d", n), int'(s2Y), n / OW2);
        n++;
      end
      holdPending = s2Valid && !s2Ready;
      heldData = int'(s2Data);
      heldX    = int'(s2X);
      heldY    = int'(s2Y);
      if (s2Done) sawDone = 1'b1;
    end
    checkOutput("s2.count", n, 9);
    checkOutput("s2.done", int'(sawDone), 1);
    s2Ready = 1'b1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    vecs[0] = '{pixMode: 0, wgtMode: 0, expKind: 1, expAll: 9,       name: "ones"};
    vecs[1] = '{pixMode: 1, wgtMode: 1, expKind: 2, expAll: 0,       name: "ramp"};
    vecs[2] = '{pixMode: 2, wgtMode: 2, expKind: 1, expAll: -293760, name: "extreme"};
    vecs[3] = '{pixMode: 3, wgtMode: 3, expKind: 0, expAll: 0,       name: "rand0"};
    vecs[4] = '{pixMode: 3, wgtMode: 3, expKind: 0, expAll: 0,       name: "rand1"};

    rstN = 1'b1; start = 1'b1; s2Start = 1'b1;
    outReady = 1'b1; s2Ready = 1'b1;
    applyStimulus(0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.busyWithStart", int'(busy), 0);
    rstN = 1'b0; start = 1'b0; s2Start = 1'b0;
    @(negedge clk);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.valid", int'(outValid), 0);
    checkOutput("reset.done", int'(done), 0);
    checkOutput("reset.data", int'(outData), 0);
    checkOutput("reset.xy", int'(outX) + int'(outY), 0);
    checkOutput("reset.s2busy", int'(s2Busy), 0);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] frame %s", vecs[i].name);
      applyStimulus(vecs[i].pixMode, vecs[i].wgtMode);
      start = 1'b1;
      collectFrame(vecs[i].expKind, vecs[i].expAll, -1, 1'b0, vecs[i].name);
    end

    @(negedge clk);
    applyStimulus(3, 3);
    start = 1'b1;
    collectFrame(0, 0, 10, 1'b0, "rstMid");
    applyStimulus(3, 3);
    start = 1'b1;
    collectFrame(0, 0, -1, 1'b0, "afterRst");

    @(negedge clk);
    applyStimulus(1, 3);
    start = 1'b1;
    collectFrame(0, 0, -1, 1'b1, "midStart");
    applyStimulus(3, 3);
    start = 1'b1;
    collectFrame(0, 0, -1, 1'b0, "backToBack");

    @(negedge clk);
    strideFrame();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
